branch_predictor: RTL

- Parametrised bimodal branch predictor with a tagged branch target buffer (BTB) for the pipelined RV32I core.
- Queried combinationally from the IF stage with the fetch PC; supplies the predicted next PC so taken branches and JAL no longer force an IF bubble.
- Trained synchronously from the EX stage once the branch/jump outcome is resolved.
- Keeps a saturating misprediction counter for performance measurement.

---
 rtl/branch_predictor_if.sv | 38 +++
 rtl/branch_predictor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Query/train/statistics bundle between the core and the branch predictor.
//   master : core side (IF-stage lookup, EX-stage update, reads the stats)
//   slave  : predictor side
// Signals:
//   lookup_valid/lookup_pc          IF-stage query
//   pred_hit/pred_taken/pred_target prediction returned in the same cycle
//   update_*                        resolved control-flow outcome from EX
//   mispredict_count                saturating misprediction count
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            update_is_jump;
  logic            update_pred_taken;
  logic [XLEN-1:0] mispredict_count;

  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_pc, update_taken, update_target,
    output update_is_jump, update_pred_taken,
    input  pred_hit, pred_taken, pred_target, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_taken, update_target,
    input  update_is_jump, update_pred_taken,
    output pred_hit, pred_taken, pred_target, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped, tagged BTB.
//   clk   : rising-edge clock for all state
//   reset : asynchronous, active-low
//   bp    : branch_predictor_if.slave (lookup, update, mispredict_count)
// Lookup is combinational and sees pre-update contents (no bypass);
// training lands on the rising edge. One BTB entry per sub-module instance.

// One BTB entry: valid/tag/target plus a saturating direction counter.
module branch_predictor_entry #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd,         // update targets this entry's index
  input  logic             upd_taken,   // effective taken (taken | jump)
  input  logic             upd_jump,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [XLEN-1:0]  upd_target,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [XLEN-1:0]  target,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic hit;
  assign hit = valid && (tag == upd_tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      cnt    <= CNT_WNT;
    end else if (upd) begin
      if (hit) begin
        if (upd_jump) begin
          cnt    <= CNT_MAX;
          target <= upd_target;
        end else if (upd_taken) begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          target <= upd_target;
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Miss on a taken branch: evict whatever alias lives here.
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        cnt    <= upd_jump ? CNT_MAX : CNT_WT;
      end
    end
  end
endmodule

module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]            ent_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] ent_tag;
  logic [ENTRIES-1:0][XLEN-1:0]  ent_target;
  logic [ENTRIES-1:0][CNT_W-1:0] ent_cnt;

  // Shifts rather than slices so every PC bit is consumed; pc[1:0] and the
  // bits above the tag fall away in the truncation.
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  assign lk_idx = IDX_W'(bp.lookup_pc >> 2);
  assign lk_tag = TAG_W'(bp.lookup_pc >> (IDX_W + 2));
  assign up_idx = IDX_W'(bp.update_pc >> 2);
  assign up_tag = TAG_W'(bp.update_pc >> (IDX_W + 2));

  logic eff_taken;
  assign eff_taken = bp.update_taken || bp.update_is_jump;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    branch_predictor_entry #(
      .XLEN (XLEN),
      .TAG_W(TAG_W),
      .CNT_W(CNT_W)
    ) u_entry (
      .clk       (clk),
      .reset     (reset),
      .upd       (bp.update_valid && (up_idx == IDX_W'(g))),
      .upd_taken (eff_taken),
      .upd_jump  (bp.update_is_jump),
      .upd_tag   (up_tag),
      .upd_target(bp.update_target),
      .valid     (ent_valid[g]),
      .tag       (ent_tag[g]),
      .target    (ent_target[g]),
      .cnt       (ent_cnt[g])
    );
  end

  // Lookup: reset gating keeps the prediction quiet while reset is held.
  logic lk_hit, lk_taken;
  assign lk_hit   = reset && bp.lookup_valid && ent_valid[lk_idx] &&
                    (ent_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ent_cnt[lk_idx][CNT_W-1];

  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? ent_target[lk_idx] : bp.lookup_pc + XLEN'(4);

  // Misprediction counter saturates at all-ones.
  logic [XLEN-1:0] mis_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mis_cnt <= '0;
    else if (bp.update_valid && (bp.update_pred_taken != eff_taken) && (mis_cnt != '1))
      mis_cnt <= mis_cnt + XLEN'(1);
  end
  assign bp.mispredict_count = mis_cnt;
endmodule
